// File: rtl/mmio_pkg.sv
// Shared types and MMIO address map for the IOBUS arbiter, its wrapper and benches.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    ACK
  } state_e;

  typedef enum logic {
    M0,
    M1
  } master_e;

  localparam logic [31:0] MMIO_SWITCHES_ADDR = 32'h1100_0000;
  localparam logic [31:0] MMIO_LEDS_ADDR     = 32'h1100_0020;
  localparam logic [31:0] MMIO_SSEG_ADDR     = 32'h1100_0040;

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-master winner select: round-robin on last_grant, or fixed M0 priority.
module rr_pick2
  import mmio_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic    req0,
  input  logic    req1,
  input  master_e last_grant,
  output logic    any_req,
  output master_e winner
);

  always_comb begin
    any_req = req0 | req1;
    winner  = M0;
    if (RR_EN) begin
      if (req0 && req1) begin
        winner = (last_grant == M0) ? M1 : M0;
      end else if (req1) begin
        winner = M1;
      end
    end else if (!req0 && req1) begin
      winner = M1;
    end
  end

endmodule

// File: rtl/mmio_bus_arbiter.sv
// Two-master MMIO IOBUS arbiter: one registered bus transaction per grant, one-cycle ACK,
// optional locked back-to-back ownership for the current winner.
module mmio_bus_arbiter
  import mmio_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter bit RR_EN  = 1'b1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              M0_REQ,
  input  logic              M0_WR,
  input  logic [ADDR_W-1:0] M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  input  logic              M0_LOCK,
  output logic              M0_GNT,
  output logic              M0_ACK,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M1_REQ,
  input  logic              M1_WR,
  input  logic [ADDR_W-1:0] M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  input  logic              M1_LOCK,
  output logic              M1_GNT,
  output logic              M1_ACK,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic [ADDR_W-1:0] IOBUS_ADDR,
  output logic [DATA_W-1:0] IOBUS_OUT,
  output logic              IOBUS_WR,
  input  logic [DATA_W-1:0] IOBUS_IN
);

  state_e            state_q, state_d;
  master_e           last_grant_q, last_grant_d;
  master_e           owner_q, owner_d;
  logic [ADDR_W-1:0] iobus_addr_q, iobus_addr_d;
  logic [DATA_W-1:0] iobus_out_q, iobus_out_d;
  logic              iobus_wr_q, iobus_wr_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              pick_valid;
  master_e           pick_winner;
  master_e           src;
  logic [ADDR_W-1:0] src_addr;
  logic [DATA_W-1:0] src_wdata;
  logic              src_wr;
  logic              src_req;
  logic              src_lock;

  rr_pick2 #(
    .RR_EN(RR_EN)
  ) u_pick (
    .req0      (M0_REQ),
    .req1      (M1_REQ),
    .last_grant(last_grant_q),
    .any_req   (pick_valid),
    .winner    (pick_winner)
  );

  // One request mux serves both the fresh grant in IDLE and the locked follow-on in ACK.
  always_comb begin
    src       = (state_q == IDLE) ? pick_winner : owner_q;
    src_addr  = (src == M1) ? M1_ADDR  : M0_ADDR;
    src_wdata = (src == M1) ? M1_WDATA : M0_WDATA;
    src_wr    = (src == M1) ? M1_WR    : M0_WR;
    src_req   = (src == M1) ? M1_REQ   : M0_REQ;
    src_lock  = (src == M1) ? M1_LOCK  : M0_LOCK;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    iobus_addr_d = iobus_addr_q;
    iobus_out_d  = iobus_out_q;
    iobus_wr_d   = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d      = pick_winner;
          last_grant_d = pick_winner;
          iobus_addr_d = src_addr;
          iobus_out_d  = src_wdata;
          iobus_wr_d   = src_wr;
          state_d      = XFER;
        end
      end
      XFER: begin
        if (!iobus_wr_q) begin
          if (owner_q == M1) rdata1_d = IOBUS_IN;
          else               rdata0_d = IOBUS_IN;
        end
        state_d = ACK;
      end
      ACK: begin
        if (src_lock && src_req) begin
          iobus_addr_d = src_addr;
          iobus_out_d  = src_wdata;
          iobus_wr_d   = src_wr;
          state_d      = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      last_grant_q <= M1;
      owner_q      <= M0;
      iobus_addr_q <= '0;
      iobus_out_q  <= '0;
      iobus_wr_q   <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      iobus_addr_q <= iobus_addr_d;
      iobus_out_q  <= iobus_out_d;
      iobus_wr_q   <= iobus_wr_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  assign M0_GNT     = (state_q != IDLE) && (owner_q == M0);
  assign M1_GNT     = (state_q != IDLE) && (owner_q == M1);
  assign M0_ACK     = (state_q == ACK) && (owner_q == M0);
  assign M1_ACK     = (state_q == ACK) && (owner_q == M1);
  assign M0_RDATA   = rdata0_q;
  assign M1_RDATA   = rdata1_q;
  assign IOBUS_ADDR = iobus_addr_q;
  assign IOBUS_OUT  = iobus_out_q;
  assign IOBUS_WR   = iobus_wr_q;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// Bench for mmio_bus_arbiter: vector table, corner sequences, and a randomized phase
// scored against a memory-backed transaction model.
module tb_mmio_bus_arbiter;
  import mmio_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req, m0_wr, m0_lock, m1_req, m1_wr, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] iobus_in, vec_in;
  logic        rand_mode;
  logic [31:0] mem [16];

  logic        r_m0_gnt, r_m0_ack, r_m1_gnt, r_m1_ack, r_iobus_wr;
  logic [31:0] r_m0_rdata, r_m1_rdata, r_iobus_addr, r_iobus_out;
  logic        f_m0_gnt, f_m0_ack, f_m1_gnt, f_m1_ack, f_iobus_wr;
  logic [31:0] f_m0_rdata, f_m1_rdata, f_iobus_addr, f_iobus_out;

  always_comb iobus_in = rand_mode ? mem[r_iobus_addr[5:2]] : vec_in;

  mmio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b1)) dut_rr (
    .CLK(clk), .RST_N(rst_n),
    .M0_REQ(m0_req), .M0_WR(m0_wr), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_LOCK(m0_lock),
    .M0_GNT(r_m0_gnt), .M0_ACK(r_m0_ack), .M0_RDATA(r_m0_rdata),
    .M1_REQ(m1_req), .M1_WR(m1_wr), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_LOCK(m1_lock),
    .M1_GNT(r_m1_gnt), .M1_ACK(r_m1_ack), .M1_RDATA(r_m1_rdata),
    .IOBUS_ADDR(r_iobus_addr), .IOBUS_OUT(r_iobus_out), .IOBUS_WR(r_iobus_wr), .IOBUS_IN(iobus_in)
  );

  mmio_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1'b0)) dut_fp (
    .CLK(clk), .RST_N(rst_n),
    .M0_REQ(m0_req), .M0_WR(m0_wr), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata), .M0_LOCK(m0_lock),
    .M0_GNT(f_m0_gnt), .M0_ACK(f_m0_ack), .M0_RDATA(f_m0_rdata),
    .M1_REQ(m1_req), .M1_WR(m1_wr), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata), .M1_LOCK(m1_lock),
    .M1_GNT(f_m1_gnt), .M1_ACK(f_m1_ack), .M1_RDATA(f_m1_rdata),
    .IOBUS_ADDR(f_iobus_addr), .IOBUS_OUT(f_iobus_out), .IOBUS_WR(f_iobus_wr), .IOBUS_IN(iobus_in)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_wr = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1, in;
    logic        rr_win, fp_win;
  } vec_t;

  vec_t vecs [7];

  task automatic check_win(input string nm, input logic win, input logic [1:0] gnt,
                           input logic [31:0] addr, input logic wr, input logic [31:0] out,
                           input vec_t v);
    chk({nm, "_gnt"}, {30'd0, gnt}, win ? 32'd2 : 32'd1);
    chk({nm, "_addr"}, addr, win ? v.a1 : v.a0);
    chk({nm, "_wr"}, {31'd0, wr}, {31'd0, win ? v.w1 : v.w0});
    if (win ? v.w1 : v.w0) chk({nm, "_out"}, out, win ? v.d1 : v.d0);
  endtask

  // Random-phase master model: each outstanding transaction and what it has seen so far.
  logic       has_txn [2];
  logic       t_wr [2];
  logic [3:0] t_idx [2];
  logic [31:0] t_data [2];
  logic       t_written [2];
  int         t_wait [2];
  int         t_others [2];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_cyc_r [$];
    int ack_who_r [$];
    int ack_cyc_f [$];
    int ack_who_f [$];
    int m1_acks [$];
    int m0_acks [$];
    logic [31:0] seen_wdata [$];
    logic [31:0] wd [3];
    int k;

    rand_mode = 0;
    vec_in = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_gnt_ack_rr", {28'd0, r_m1_gnt, r_m0_gnt, r_m1_ack, r_m0_ack}, 0);
    chk("rst_gnt_ack_fp", {28'd0, f_m1_gnt, f_m0_gnt, f_m1_ack, f_m0_ack}, 0);
    chk("rst_iobus_wr", {30'd0, r_iobus_wr, f_iobus_wr}, 0);
    chk("rst_iobus_addr", r_iobus_addr, 0);
    chk("rst_iobus_out", r_iobus_out, 0);
    chk("rst_rdata0", r_m0_rdata, 0);
    chk("rst_rdata1", r_m1_rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vectors run back-to-back; the round-robin winner follows from the previous vectors.
    vecs[0] = '{1, 0, 0, 0, MMIO_SWITCHES_ADDR, 0, 0, 0, 32'h0000_A5A5, 0, 0};
    vecs[1] = '{0, 1, 0, 1, 0, MMIO_LEDS_ADDR, 0, 32'h1234, 32'hFFFF_FFFF, 1, 1};
    vecs[2] = '{1, 1, 0, 0, MMIO_SWITCHES_ADDR, MMIO_SSEG_ADDR, 0, 0, 32'h0000_BEEF, 0, 0};
    vecs[3] = '{1, 1, 1, 1, MMIO_LEDS_ADDR, MMIO_SSEG_ADDR, 32'h11, 32'h22, 32'h0, 1, 0};
    vecs[4] = '{1, 1, 0, 0, MMIO_SSEG_ADDR, MMIO_SWITCHES_ADDR, 0, 0, 32'h77, 0, 0};
    vecs[5] = '{1, 0, 0, 0, MMIO_LEDS_ADDR, 0, 0, 0, 32'hCAFE_F00D, 0, 0};
    vecs[6] = '{1, 1, 1, 0, MMIO_SSEG_ADDR, MMIO_LEDS_ADDR, 32'h5555, 0, 32'h9, 1, 0};

    for (int i = 0; i < 7; i++) begin
      vec_t v;
      logic rr_rd, fp_rd;
      v = vecs[i];
      m0_req = v.r0; m0_wr = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
      m1_req = v.r1; m1_wr = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
      vec_in = v.in;
      rr_rd = !(v.rr_win ? v.w1 : v.w0);
      fp_rd = !(v.fp_win ? v.w1 : v.w0);
      @(negedge clk);
      check_win($sformatf("v%0d_rr", i), v.rr_win, {r_m1_gnt, r_m0_gnt}, r_iobus_addr, r_iobus_wr, r_iobus_out, v);
      check_win($sformatf("v%0d_fp", i), v.fp_win, {f_m1_gnt, f_m0_gnt}, f_iobus_addr, f_iobus_wr, f_iobus_out, v);
      @(negedge clk);
      chk($sformatf("v%0d_rr_ack", i), {30'd0, r_m1_ack, r_m0_ack}, v.rr_win ? 2 : 1);
      chk($sformatf("v%0d_fp_ack", i), {30'd0, f_m1_ack, f_m0_ack}, v.fp_win ? 2 : 1);
      chk($sformatf("v%0d_wr_low_in_ack", i), {30'd0, r_iobus_wr, f_iobus_wr}, 0);
      if (rr_rd) chk($sformatf("v%0d_rr_rdata", i), v.rr_win ? r_m1_rdata : r_m0_rdata, v.in);
      if (fp_rd) chk($sformatf("v%0d_fp_rdata", i), v.fp_win ? f_m1_rdata : f_m0_rdata, v.in);
      m0_req = 0; m1_req = 0;
      @(negedge clk);
      chk($sformatf("v%0d_idle_gnt", i), {28'd0, r_m1_gnt, r_m0_gnt, f_m1_gnt, f_m0_gnt}, 0);
      if (rr_rd) chk($sformatf("v%0d_rr_rdata_held", i), v.rr_win ? r_m1_rdata : r_m0_rdata, v.in);
    end

    // Continuous contention: four transactions on each arbiter.
    do_reset();
    m0_req = 1; m0_addr = MMIO_SWITCHES_ADDR;
    m1_req = 1; m1_addr = MMIO_LEDS_ADDR;
    vec_in = 32'h123;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("cont_gnt_excl", {31'd0, r_m0_gnt & r_m1_gnt}, 0);
      if (r_m0_ack | r_m1_ack) begin ack_cyc_r.push_back(c); ack_who_r.push_back(r_m1_ack ? 1 : 0); end
      if (f_m0_ack | f_m1_ack) begin ack_cyc_f.push_back(c); ack_who_f.push_back(f_m1_ack ? 1 : 0); end
    end
    idle_inputs();
    chk("cont_rr_count", ack_cyc_r.size(), 4);
    chk("cont_fp_count", ack_cyc_f.size(), 4);
    for (int i = 0; i < ack_cyc_r.size() && i < 4; i++) begin
      chk($sformatf("cont_rr_who%0d", i), ack_who_r[i], i % 2);
      chk($sformatf("cont_rr_cyc%0d", i), ack_cyc_r[i], 1 + 3 * i);
    end
    for (int i = 0; i < ack_cyc_f.size() && i < 4; i++) begin
      chk($sformatf("cont_fp_who%0d", i), ack_who_f[i], 0);
    end
    @(negedge clk);
    @(negedge clk);

    // Locked burst: M1 three writes two cycles apart, M0 served afterwards.
    do_reset();
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2;
    k = 0;
    m1_req = 1; m1_lock = 1; m1_wr = 1; m1_addr = MMIO_LEDS_ADDR; m1_wdata = wd[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c == 0) begin m0_req = 1; m0_addr = MMIO_SWITCHES_ADDR; vec_in = 32'h5A; end
      if (r_iobus_wr) seen_wdata.push_back(r_iobus_out);
      if (r_m0_gnt && m1_req) chk("lock_m0_early_gnt", {31'd0, r_m0_gnt}, 0);
      if (r_m1_ack) begin
        m1_acks.push_back(c);
        k++;
        if (k < 3) m1_wdata = wd[k];
        else begin m1_req = 0; m1_lock = 0; end
      end
      if (r_m0_ack) begin m0_acks.push_back(c); m0_req = 0; end
    end
    chk("lock_m1_acks", m1_acks.size(), 3);
    for (int i = 0; i < m1_acks.size() && i < 3; i++) chk($sformatf("lock_m1_ack%0d", i), m1_acks[i], 1 + 2 * i);
    chk("lock_writes", seen_wdata.size(), 3);
    for (int i = 0; i < seen_wdata.size() && i < 3; i++) chk($sformatf("lock_wdata%0d", i), seen_wdata[i], wd[i]);
    chk("lock_m0_acks", m0_acks.size(), 1);
    if (m0_acks.size() > 0) chk("lock_m0_ack_cyc", m0_acks[0], 8);
    chk("lock_m0_rdata", r_m0_rdata, 32'h5A);
    idle_inputs();

    // Reset during the XFER cycle of a write.
    do_reset();
    m0_req = 1; m0_wr = 1; m0_addr = MMIO_LEDS_ADDR; m0_wdata = 32'hDEAD;
    @(negedge clk);
    chk("rstx_wr_before", {31'd0, r_iobus_wr}, 1);
    rst_n = 1'b0;
    #1;
    chk("rstx_wr_now", {31'd0, r_iobus_wr}, 0);
    chk("rstx_gnt_ack_now", {28'd0, r_m1_gnt, r_m0_gnt, r_m1_ack, r_m0_ack}, 0);
    @(negedge clk);
    chk("rstx_no_ack", {28'd0, r_m1_gnt, r_m0_gnt, r_m1_ack, r_m0_ack}, 0);
    idle_inputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstx_idle", {28'd0, r_m1_gnt, r_m0_gnt, r_m1_ack, r_m0_ack}, 0);
    m1_req = 1; m1_addr = MMIO_SSEG_ADDR; vec_in = 32'h4242;
    @(negedge clk);
    chk("rstx_next_gnt", {30'd0, r_m1_gnt, r_m0_gnt}, 2);
    chk("rstx_next_addr", r_iobus_addr, MMIO_SSEG_ADDR);
    @(negedge clk);
    chk("rstx_next_ack", {30'd0, r_m1_ack, r_m0_ack}, 2);
    chk("rstx_next_rdata", r_m1_rdata, 32'h4242);
    idle_inputs();

    // Randomized traffic against the memory-backed model.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rand_mode = 1;
    for (int m = 0; m < 2; m++) begin
      has_txn[m] = 0; t_wr[m] = 0; t_idx[m] = '0; t_data[m] = '0;
      t_written[m] = 0; t_wait[m] = 0; t_others[m] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      logic [1:0] ack, gnt;
      @(negedge clk);
      ack = {r_m1_ack, r_m0_ack};
      gnt = {r_m1_gnt, r_m0_gnt};
      chk("rnd_gnt_excl", {31'd0, gnt == 2'b11}, 0);
      chk("rnd_ack_excl", {31'd0, ack == 2'b11}, 0);
      if (r_iobus_wr) begin
        int m;
        m = r_m1_gnt ? 1 : 0;
        chk("rnd_wr_owner", {31'd0, has_txn[m] && t_wr[m] && !t_written[m]}, 1);
        chk("rnd_wr_addr", r_iobus_addr, 32'h1100_0000 + {26'd0, t_idx[m], 2'b00});
        chk("rnd_wr_data", r_iobus_out, t_data[m]);
        mem[r_iobus_addr[5:2]] = r_iobus_out;
        t_written[m] = 1;
      end
      for (int m = 0; m < 2; m++) begin
        if (ack[m]) begin
          chk($sformatf("rnd_m%0d_ack_has_txn", m), {31'd0, has_txn[m]}, 1);
          if (has_txn[m]) begin
            if (t_wr[m]) chk($sformatf("rnd_m%0d_write_landed", m), {31'd0, t_written[m]}, 1);
            else chk($sformatf("rnd_m%0d_rdata", m), m ? r_m1_rdata : r_m0_rdata, mem[t_idx[m]]);
            chk($sformatf("rnd_m%0d_rr_fair", m), {31'd0, t_others[m] <= 1}, 1);
          end
          has_txn[m] = 0;
        end else if (has_txn[m]) begin
          if (ack[1-m]) t_others[m]++;
          t_wait[m]++;
          if (t_wait[m] > 10) begin
            chk($sformatf("rnd_m%0d_wait_bound", m), t_wait[m], 10);
            has_txn[m] = 0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          has_txn[m] = 1;
          t_wr[m] = $urandom_range(0, 1);
          t_idx[m] = 4'($urandom_range(0, 15));
          t_data[m] = $urandom;
          t_written[m] = 0;
          t_wait[m] = 0;
          t_others[m] = 0;
        end
      end
      m0_req = has_txn[0]; m0_wr = t_wr[0]; m0_wdata = t_data[0];
      m0_addr = 32'h1100_0000 + {26'd0, t_idx[0], 2'b00};
      m1_req = has_txn[1]; m1_wr = t_wr[1]; m1_wdata = t_data[1];
      m1_addr = 32'h1100_0000 + {26'd0, t_idx[1], 2'b00};
    end
    idle_inputs();
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
